// File: rtl/product_accumulator_if.sv
// Product-stream input and result-buffer handshake bundle for product_accumulator.
// The master drives products and out_ready; the slave (accumulator) returns results.
interface product_accumulator_if #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 20
) ();
    logic             in_valid;
    logic [IN_W-1:0]  in_product;
    logic             in_clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_sat;
    logic             overrun;

    modport master (
        output in_valid, in_product, in_clear, out_ready,
        input  out_valid, out_sum, out_sat, overrun
    );

    modport slave (
        input  in_valid, in_product, in_clear, out_ready,
        output out_valid, out_sum, out_sat, overrun
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums groups of LEN unsigned products with saturation into a one-entry result
// buffer; never back-pressures the product stream, drops results when full.
module product_accumulator #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 20,
    parameter int LEN   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    product_accumulator_if.slave bus
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t       state;
    logic [ACC_W-1:0] acc;
    logic             sat_acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] sum_reg;
    logic             sat_reg;
    logic             overrun_reg;

    logic [ACC_W-1:0] base_acc;
    logic             base_sat;
    logic [CNT_W-1:0] base_cnt;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum;
    logic             sum_sat;
    logic             push;
    logic             pop;

    // in_clear with a valid product restarts the group at this product, so the
    // adder simply sees a zeroed accumulator and counter.
    always_comb begin
        base_acc = bus.in_clear ? '0 : acc;
        base_sat = bus.in_clear ? 1'b0 : sat_acc;
        base_cnt = bus.in_clear ? '0 : cnt;
        sum_wide = {1'b0, base_acc} + (ACC_W + 1)'(bus.in_product);
        sum      = sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];
        sum_sat  = base_sat | sum_wide[ACC_W];
        push     = bus.in_valid && (base_cnt == LAST);
        pop      = (state == FULL) && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= EMPTY;
            acc         <= '0;
            sat_acc     <= 1'b0;
            cnt         <= '0;
            sum_reg     <= '0;
            sat_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                if (push) begin
                    acc     <= '0;
                    sat_acc <= 1'b0;
                    cnt     <= '0;
                end else begin
                    acc     <= sum;
                    sat_acc <= sum_sat;
                    cnt     <= base_cnt + CNT_W'(1);
                end
            end else if (bus.in_clear) begin
                acc     <= '0;
                sat_acc <= 1'b0;
                cnt     <= '0;
            end

            case (state)
                EMPTY: begin
                    if (push) begin
                        sum_reg <= sum;
                        sat_reg <= sum_sat;
                        state   <= FULL;
                    end
                end
                FULL: begin
                    if (pop) begin
                        if (push) begin
                            sum_reg <= sum;
                            sat_reg <= sum_sat;
                        end else begin
                            state <= EMPTY;
                        end
                    end else if (push) begin
                        overrun_reg <= 1'b1;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_sum   = sum_reg;
    assign bus.out_sat   = sat_reg;
    assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_product_accumulator.sv
// Drives ACC_W=20 and ACC_W=17 accumulators with identical stimulus and checks
// them every cycle against an unbounded-integer group-sum model.
module tb_product_accumulator;
    localparam int LEN = 4;
    localparam int unsigned MAX0 = (1 << 20) - 1;
    localparam int unsigned MAX1 = (1 << 17) - 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        v = 1'b0;
    logic [15:0] p = '0;
    logic        clr = 1'b0;
    logic        rdy = 1'b0;

    int total = 0;
    int bad = 0;

    // model state per instance: 0 -> ACC_W=20, 1 -> ACC_W=17
    int unsigned gsum [2];
    int unsigned gcnt [2];
    logic        m_valid [2];
    int unsigned m_sum [2];
    logic        m_sat [2];
    logic        m_ovr [2];

    product_accumulator_if #(.IN_W(16), .ACC_W(20)) bus0 ();
    product_accumulator_if #(.IN_W(16), .ACC_W(17)) bus1 ();

    assign bus0.in_valid = v;
    assign bus0.in_product = p;
    assign bus0.in_clear = clr;
    assign bus0.out_ready = rdy;
    assign bus1.in_valid = v;
    assign bus1.in_product = p;
    assign bus1.in_clear = clr;
    assign bus1.out_ready = rdy;

    product_accumulator #(.IN_W(16), .ACC_W(20), .LEN(LEN)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    product_accumulator #(.IN_W(16), .ACC_W(17), .LEN(LEN)) dut17 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int unsigned maxv;
            int unsigned s;
            int unsigned c;
            logic push;
            logic pop;
            int unsigned res;
            logic rsat;
            maxv = (k == 0) ? MAX0 : MAX1;
            push = 1'b0;
            res = 0;
            rsat = 1'b0;
            if (!reset_n) begin
                gsum[k] = 0; gcnt[k] = 0;
                m_valid[k] = 1'b0; m_sum[k] = 0; m_sat[k] = 1'b0; m_ovr[k] = 1'b0;
                continue;
            end
            pop = m_valid[k] && rdy;
            if (v) begin
                s = (clr ? 0 : gsum[k]) + p;
                c = (clr ? 0 : gcnt[k]) + 1;
                if (c == LEN) begin
                    push = 1'b1;
                    res = (s > maxv) ? maxv : s;
                    rsat = (s > maxv);
                    gsum[k] = 0; gcnt[k] = 0;
                end else begin
                    gsum[k] = s; gcnt[k] = c;
                end
            end else if (clr) begin
                gsum[k] = 0; gcnt[k] = 0;
            end
            if (push && (!m_valid[k] || pop)) begin
                m_valid[k] = 1'b1; m_sum[k] = res; m_sat[k] = rsat;
            end else if (push) begin
                m_ovr[k] = 1'b1;
            end else if (pop) begin
                m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("valid20", bus0.out_valid, m_valid[0]);
        check("sum20", bus0.out_sum, m_sum[0]);
        check("sat20", bus0.out_sat, m_sat[0]);
        check("ovr20", bus0.overrun, m_ovr[0]);
        check("valid17", bus1.out_valid, m_valid[1]);
        check("sum17", bus1.out_sum, m_sum[1]);
        check("sat17", bus1.out_sat, m_sat[1]);
        check("ovr17", bus1.overrun, m_ovr[1]);
    endtask

    task automatic step(input logic iv, input int unsigned ip, input logic ic, input logic ir);
        v = iv;
        p = 16'(ip);
        clr = ic;
        rdy = ir;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1'b0, 0, 1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        check("rst_valid", bus0.out_valid, 0);
        check("rst_sum", bus0.out_sum, 0);

        // basic group of four
        step(1, 100, 0, 1); step(1, 200, 0, 1); step(1, 300, 0, 1); step(1, 400, 0, 1);
        check("t1_valid", bus0.out_valid, 1);
        check("t1_sum", bus0.out_sum, 1000);
        check("t1_sat", bus0.out_sat, 0);
        step(0, 0, 0, 1);
        check("t1_pop", bus0.out_valid, 0);

        // gaps inside a group, saturation at 17 bits
        step(1, 65535, 0, 1); step(1, 65535, 0, 1);
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        step(1, 65535, 0, 0); step(1, 65535, 0, 0);
        check("t2_sum20", bus0.out_sum, 262140);
        check("t2_sat20", bus0.out_sat, 0);
        check("t2_sum17", bus1.out_sum, 131071);
        check("t2_sat17", bus1.out_sat, 1);
        step(0, 0, 0, 1);

        // overrun: first result held, later ones dropped
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
        check("t3_sum", bus0.out_sum, 4);
        check("t3_ovr", bus0.overrun, 1);
        step(0, 0, 0, 0);
        check("t3_hold", bus0.out_sum, 4);
        step(0, 0, 0, 1);
        check("t3_pop", bus0.out_valid, 0);

        // pop and push on the same edge
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 3, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 5, 0, 0);
        step(1, 5, 0, 1);
        check("t4_valid", bus0.out_valid, 1);
        check("t4_sum", bus0.out_sum, 20);
        check("t4_ovr", bus0.overrun, 0);
        step(0, 0, 0, 1);

        // in_clear with a product, then in_clear alone
        step(1, 5, 0, 1); step(1, 5, 0, 1); step(1, 7, 1, 1);
        step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
        check("t5_sum", bus0.out_sum, 10);
        step(1, 3, 0, 1); step(1, 3, 0, 1); step(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 2, 0, 1);
        check("t5_discard", bus0.out_sum, 8);
        step(0, 0, 0, 1);

        // reset mid-group with full buffer and overrun set
        for (int i = 0; i < 8; i++) step(1, 9, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 9, 0, 0);
        check("t6_pre_ovr", bus0.overrun, 1);
        do_reset();
        check("t6_valid", bus0.out_valid, 0);
        check("t6_sum", bus0.out_sum, 0);
        check("t6_sat", bus0.out_sat, 0);
        check("t6_ovr", bus0.overrun, 0);
        for (int i = 0; i < 4; i++) step(1, 2, 0, 1);
        check("t6_sum2", bus0.out_sum, 8);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int unsigned pv;
            pv = ($urandom_range(0, 3) == 0) ? 65535 : $urandom_range(0, 65535);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7, pv,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
